// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-flow controller for the nibble CPU.
// Captures opcode bytes on phase==1 clock edges, redirects the PC for
// jumps/calls/returns through a small return-address stack, and issues a
// one-clock execute pulse for every ordinary datapath opcode.
module fetch_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              phase,
  input  logic [7:0]        instr,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              carry,
  input  logic              zero,
  output logic              pc_enable,
  output logic [ADDR_W-1:0] pc_newaddr,
  output logic              exec_valid,
  output logic [7:0]        exec_op,
  output logic              halted,
  output logic              stack_err
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_TARGET = 2'd1;
  localparam logic [1:0] ST_HALT   = 2'd2;

  localparam logic [3:0] OP_HALT = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JNZ  = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hE;
  localparam logic [3:0] OP_RET  = 4'hF;

  localparam logic [SP_W-1:0] SP_FULL  = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_EMPTY = {SP_W{1'b0}};

  // Branch condition for a pending two-byte opcode given the live flags.
  function automatic logic branch_taken(input logic [3:0] op, input logic c, input logic z);
    logic t;
    case (op)
      OP_JMP:  t = 1'b1;
      OP_JC:   t = c;
      OP_JZ:   t = z;
      OP_JNZ:  t = ~z;
      OP_CALL: t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Opcodes 0xA..0xE carry a second (target low) byte.
  function automatic logic is_two_byte(input logic [3:0] op);
    return (op >= OP_JMP) && (op <= OP_CALL);
  endfunction

  logic [1:0]        state_r;
  logic [SP_W-1:0]   sp_r;
  logic [3:0]        hi_nib_r;
  logic [3:0]        pend_op_r;
  logic              exec_valid_r;
  logic [7:0]        exec_op_r;
  logic              halted_r;
  logic              stack_err_r;
  logic [ADDR_W-1:0] stack_mem_r [STACK_DEPTH];

  logic [3:0]        opcode_s;
  logic              sp_empty_s;
  logic              sp_full_s;
  logic [IDX_W-1:0]  top_idx_s;
  logic [ADDR_W-1:0] stack_top_s;
  logic [ADDR_W-1:0] target_s;
  logic              push_s;
  logic              pc_enable_s;
  logic [ADDR_W-1:0] pc_newaddr_s;

  // Decode helpers: opcode field, stack occupancy, top entry and jump target.
  always_comb begin
    opcode_s    = instr[7:4];
    sp_empty_s  = (sp_r == SP_EMPTY);
    sp_full_s   = (sp_r == SP_FULL);
    top_idx_s   = sp_r[IDX_W-1:0] - IDX_W'(1);
    stack_top_s = stack_mem_r[top_idx_s];
    target_s    = ADDR_W'({hi_nib_r, instr});
    if (!Rst && phase && (state_r == ST_TARGET) && (pend_op_r == OP_CALL) && !sp_full_s) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // PC load request: RET in FETCH or a taken branch in TARGET, only while phase==1.
  always_comb begin
    pc_enable_s  = 1'b0;
    pc_newaddr_s = {ADDR_W{1'b0}};
    if (!Rst && phase) begin
      case (state_r)
        ST_FETCH: begin
          if (opcode_s == OP_RET) begin
            pc_enable_s = 1'b1;
            if (sp_empty_s) begin
              pc_newaddr_s = {ADDR_W{1'b0}};
            end else begin
              pc_newaddr_s = stack_top_s;
            end
          end else begin
            pc_enable_s  = 1'b0;
            pc_newaddr_s = {ADDR_W{1'b0}};
          end
        end
        ST_TARGET: begin
          if (branch_taken(pend_op_r, carry, zero)) begin
            pc_enable_s  = 1'b1;
            pc_newaddr_s = target_s;
          end else begin
            pc_enable_s  = 1'b0;
            pc_newaddr_s = {ADDR_W{1'b0}};
          end
        end
        default: begin
          pc_enable_s  = 1'b0;
          pc_newaddr_s = {ADDR_W{1'b0}};
        end
      endcase
    end else begin
      pc_enable_s  = 1'b0;
      pc_newaddr_s = {ADDR_W{1'b0}};
    end
  end

  // Control state, stack pointer and registered outputs; advance only on capture edges.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_r      <= ST_FETCH;
      sp_r         <= SP_EMPTY;
      hi_nib_r     <= 4'h0;
      pend_op_r    <= 4'h0;
      exec_valid_r <= 1'b0;
      exec_op_r    <= 8'h00;
      halted_r     <= 1'b0;
      stack_err_r  <= 1'b0;
    end else begin
      exec_valid_r <= 1'b0;
      if (phase) begin
        case (state_r)
          ST_FETCH: begin
            if (is_two_byte(opcode_s)) begin
              hi_nib_r  <= instr[3:0];
              pend_op_r <= opcode_s;
              state_r   <= ST_TARGET;
            end else if (opcode_s == OP_RET) begin
              if (sp_empty_s) begin
                stack_err_r <= 1'b1;
              end else begin
                sp_r <= sp_r - SP_W'(1);
              end
            end else if (opcode_s == OP_HALT) begin
              state_r  <= ST_HALT;
              halted_r <= 1'b1;
            end else begin
              exec_op_r    <= instr;
              exec_valid_r <= 1'b1;
            end
          end
          ST_TARGET: begin
            if (pend_op_r == OP_CALL) begin
              if (sp_full_s) begin
                stack_err_r <= 1'b1;
              end else begin
                sp_r <= sp_r + SP_W'(1);
              end
            end
            state_r <= ST_FETCH;
          end
          ST_HALT: begin
            state_r <= ST_HALT;
          end
          default: begin
            state_r <= ST_FETCH;
          end
        endcase
      end
    end
  end

  // Return-address storage; contents survive reset, only sp is cleared.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_mem_r[sp_r[IDX_W-1:0]] <= pc_addr + ADDR_W'(1);
    end
  end

  assign pc_enable  = pc_enable_s;
  assign pc_newaddr = pc_newaddr_s;
  assign exec_valid = exec_valid_r;
  assign exec_op    = exec_op_r;
  assign halted     = halted_r;
  assign stack_err  = stack_err_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by random
// instruction streams, compared against an instruction-level reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        Rst;
  logic        phase;
  logic [7:0]  instr;
  logic [11:0] pc_addr;
  logic        carry;
  logic        zero;
  logic        pc_enable;
  logic [11:0] pc_newaddr;
  logic        exec_valid;
  logic [7:0]  exec_op;
  logic        halted;
  logic        stack_err;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural view of the sequencer.
  logic [11:0] stk[$];
  bit          m_pend;
  logic [3:0]  m_op;
  logic [3:0]  m_hi;
  bit          m_halt;
  bit          m_err;
  bit          m_ev;
  logic [7:0]  m_exec_op;
  logic [11:0] pc;
  logic        last_en;
  logic [11:0] last_addr;

  fetch_sequencer #(.ADDR_W(12), .STACK_DEPTH(4)) dut (
    .clk(clk), .Rst(Rst), .phase(phase), .instr(instr), .pc_addr(pc_addr),
    .carry(carry), .zero(zero), .pc_enable(pc_enable), .pc_newaddr(pc_newaddr),
    .exec_valid(exec_valid), .exec_op(exec_op), .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_pend = 1'b0; m_op = 4'h0; m_hi = 4'h0;
    m_halt = 1'b0; m_err = 1'b0; m_ev = 1'b0; m_exec_op = 8'h00;
  endtask

  // One capture of byte b: returns the PC load the architecture demands.
  task automatic model_capture(input logic [7:0] b, input logic c, input logic z,
                               output logic en, output logic [11:0] addr);
    logic [3:0] op;
    op = b[7:4];
    en = 1'b0; addr = 12'h000; m_ev = 1'b0;
    if (m_halt) begin
      en = 1'b0;
    end else if (m_pend) begin
      en = (m_op == 4'hA) || (m_op == 4'hE) || (m_op == 4'hB && c) ||
           (m_op == 4'hC && z) || (m_op == 4'hD && !z);
      if (en) addr = {m_hi, b};
      if (m_op == 4'hE) begin
        if (stk.size() < 4) stk.push_back(pc + 12'h001);
        else m_err = 1'b1;
      end
      m_pend = 1'b0;
    end else if (op >= 4'hA && op <= 4'hE) begin
      m_pend = 1'b1; m_op = op; m_hi = b[3:0];
    end else if (op == 4'hF) begin
      en = 1'b1;
      if (stk.size() > 0) addr = stk.pop_back();
      else m_err = 1'b1;
    end else if (op == 4'h9) begin
      m_halt = 1'b1;
    end else begin
      m_ev = 1'b1; m_exec_op = b;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    Rst = 1'b1; phase = 1'b1; instr = 8'hF0;
    #1;
    check("rst_pc_enable", 32'(pc_enable), 32'(0));
    check("rst_pc_newaddr", 32'(pc_newaddr), 32'(0));
    check("rst_exec_valid", 32'(exec_valid), 32'(0));
    check("rst_exec_op", 32'(exec_op), 32'(0));
    check("rst_halted", 32'(halted), 32'(0));
    check("rst_stack_err", 32'(stack_err), 32'(0));
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("rst_hold_pc_enable", 32'(pc_enable), 32'(0));
    check("rst_hold_exec_valid", 32'(exec_valid), 32'(0));
    Rst = 1'b0; phase = 1'b0;
    model_reset();
  endtask

  // One phase pair: capture cycle with byte b, then a non-capture cycle.
  task automatic step(input logic [7:0] b, input logic c, input logic z);
    logic        en;
    logic [11:0] addr;
    @(negedge clk);
    check("exec_valid_one_clock", 32'(exec_valid), 32'(0));
    phase = 1'b1; instr = b; carry = c; zero = z; pc_addr = pc;
    #1;
    model_capture(b, c, z, en, addr);
    check("pc_enable", 32'(pc_enable), 32'(en));
    check("pc_newaddr", 32'(pc_newaddr), 32'(addr));
    last_en = pc_enable; last_addr = pc_newaddr;
    pc = en ? addr : pc + 12'h001;
    @(negedge clk);
    check("exec_valid", 32'(exec_valid), 32'(m_ev));
    check("exec_op", 32'(exec_op), 32'(m_exec_op));
    check("halted", 32'(halted), 32'(m_halt));
    check("stack_err", 32'(stack_err), 32'(m_err));
    phase = 1'b0; instr = 8'($urandom); carry = 1'($urandom); zero = 1'($urandom);
    pc_addr = 12'($urandom);
    #1;
    check("idle_pc_enable", 32'(pc_enable), 32'(0));
    check("idle_pc_newaddr", 32'(pc_newaddr), 32'(0));
  endtask

  initial begin
    logic [11:0] ret_exp [5];
    logic [7:0]  b;
    Rst = 1'b0; phase = 1'b0; instr = 8'h00; pc_addr = 12'h000;
    carry = 1'b0; zero = 1'b0; pc = 12'h000;
    last_en = 1'b0; last_addr = 12'h000;
    model_reset();

    // Reset then an ALU op
    do_reset(6);
    step(8'h35, 1'b0, 1'b0);
    check("alu_exec_op", 32'(exec_op), 32'h35);
    check("alu_no_load", 32'(last_en), 32'(0));

    // JMP 0x359
    step(8'hA3, 1'b0, 1'b0);
    check("jmp_first_no_load", 32'(last_en), 32'(0));
    step(8'h59, 1'b0, 1'b0);
    check("jmp_load", 32'(last_en), 32'(1));
    check("jmp_addr", 32'(last_addr), 32'h359);

    // JZ not taken, JNZ taken
    step(8'hC1, 1'b0, 1'b0);
    step(8'h20, 1'b0, 1'b0);
    check("jz_not_taken", 32'(last_en), 32'(0));
    step(8'hD1, 1'b0, 1'b0);
    step(8'h20, 1'b0, 1'b0);
    check("jnz_taken", 32'(last_en), 32'(1));
    check("jnz_addr", 32'(last_addr), 32'h120);

    // CALL at 0x010 to 0x400, then RET
    pc = 12'h010;
    step(8'hE4, 1'b1, 1'b1);
    step(8'h00, 1'b0, 1'b0);
    check("call_addr", 32'(last_addr), 32'h400);
    step(8'hF0, 1'b0, 1'b0);
    check("ret_addr", 32'(last_addr), 32'h012);
    check("no_stack_err_yet", 32'(stack_err), 32'(0));

    // Five nested CALLs then five RETs
    pc = 12'h100;
    for (int i = 0; i < 5; i++) begin
      b = 8'hE0 | 8'(i + 2);
      step(b, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0);
      check("nested_call_addr", 32'(last_addr), 32'((i + 2) * 256));
    end
    check("overflow_err", 32'(stack_err), 32'(1));
    ret_exp[0] = 12'h402; ret_exp[1] = 12'h302; ret_exp[2] = 12'h202;
    ret_exp[3] = 12'h102; ret_exp[4] = 12'h000;
    for (int i = 0; i < 5; i++) begin
      step(8'hF0, 1'b0, 1'b0);
      check("lifo_ret_addr", 32'(last_addr), 32'(ret_exp[i]));
    end
    check("err_sticky", 32'(stack_err), 32'(1));

    // Random instruction streams with occasional resets and PC jumps
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset(1 + int'($urandom_range(0, 3)));
      if ($urandom_range(0, 19) == 0) pc = 12'($urandom);
      b = 8'($urandom);
      if (b[7:4] == 4'h9) b[7:4] = 4'h3;
      step(b, 1'($urandom), 1'($urandom));
    end

    // HALT freezes everything
    do_reset(2);
    step(8'h90, 1'b0, 1'b0);
    check("halt_set", 32'(halted), 32'(1));
    step(8'h35, 1'b0, 1'b0);
    step(8'hF0, 1'b0, 1'b0);
    step(8'hA1, 1'b0, 1'b0);
    step(8'h22, 1'b0, 1'b0);
    check("halt_no_load", 32'(last_en), 32'(0));

    // Reset in the middle of a jump
    do_reset(2);
    step(8'hA7, 1'b0, 1'b0);
    do_reset(1);
    step(8'h35, 1'b0, 1'b0);
    check("after_mid_reset_exec", 32'(exec_op), 32'h35);
    step(8'hF0, 1'b0, 1'b0);
    check("after_mid_reset_empty_ret", 32'(last_addr), 32'h000);
    check("after_mid_reset_underflow", 32'(stack_err), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
